fetch_unit: RTL and testbench

Instruction fetch stage that owns the architectural fetch PC, issues instruction-memory reads, and loads the IF/ID latch. It drives the branch predictor's `pc` input and advances to the predictor's `npc` on each accepted fetch. It squashes wrong-path fetches on a redirect from branch resolution. A one-entry skid buffer and a drain state absorb decode stalls and redirects that arrive while a memory read is in flight.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues instruction reads and loads the IF/ID latch.
// A one-entry skid buffer (HOLD) absorbs decode stalls; DRAIN retires a wrong-path read after a redirect.
module fetch_unit #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pred_npc,
    input  logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_ready,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 id_stall,
    output logic                 if_valid,
    output logic [WORD_SIZE-1:0] if_instr,
    output logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] if_pred_npc,
    output logic                 if_pred_taken,
    output logic [1:0]           debug_state
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]           state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pending;
    logic                 skid_valid;
    logic [WORD_SIZE-1:0] skid_instr;
    logic [WORD_SIZE-1:0] skid_pc;
    logic [WORD_SIZE-1:0] skid_npc;
    logic                 skid_taken;
    logic                 latch_free;

    // Handshake: a read is outstanding whenever mem_req=1; mem_ready=1 completes it in that
    // same cycle. The address is a register, so it is stable for the whole request.
    assign pc_out      = pc;
    assign mem_addr    = pc;
    assign mem_req     = reset_n && ((state == FETCH) || (state == DRAIN));
    assign debug_state = state;
    assign latch_free  = !if_valid || !id_stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= FETCH;
            pc            <= '0;
            pending       <= '0;
            skid_valid    <= 1'b0;
            skid_instr    <= '0;
            skid_pc       <= '0;
            skid_npc      <= '0;
            skid_taken    <= 1'b0;
            if_valid      <= 1'b0;
            if_instr      <= '0;
            if_pc         <= '0;
            if_pred_npc   <= '0;
            if_pred_taken <= 1'b0;
        end else if (redirect) begin
            // Flush wins over stall and capture; a read still in flight must be drained first.
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        pc <= redirect_pc;
                    end else begin
                        pending <= redirect_pc;
                        state   <= DRAIN;
                    end
                end
                HOLD: begin
                    pc    <= redirect_pc;
                    state <= FETCH;
                end
                DRAIN: begin
                    if (mem_ready) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end else begin
                        pending <= redirect_pc;
                    end
                end
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        pc <= pred_npc;
                        if (latch_free) begin
                            if_valid      <= 1'b1;
                            if_instr      <= mem_data;
                            if_pc         <= pc;
                            if_pred_npc   <= pred_npc;
                            if_pred_taken <= pred_taken;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_instr <= mem_data;
                            skid_pc    <= pc;
                            skid_npc   <= pred_npc;
                            skid_taken <= pred_taken;
                            state      <= HOLD;
                        end
                    end else if (if_valid && !id_stall) begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!id_stall && skid_valid) begin
                        if_valid      <= 1'b1;
                        if_instr      <= skid_instr;
                        if_pc         <= skid_pc;
                        if_pred_npc   <= skid_npc;
                        if_pred_taken <= skid_taken;
                        skid_valid    <= 1'b0;
                        state         <= FETCH;
                    end
                end
                DRAIN: begin
                    // Wrong-path data is dropped; fetch resumes at the saved redirect target.
                    if (mem_ready) begin
                        pc    <= pending;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory model, pc+1 predictor with one hit entry,
// directed scenarios plus a random phase, all backed by an in-order entry scoreboard.
module tb_fetch_unit;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pred_npc;
    logic        pred_taken;
    logic [15:0] pc_out;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pred_npc;
    logic        if_pred_taken;
    logic [1:0]  debug_state;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_pops = 0;
    int          wait_n = 0;
    int          wait_cnt = 0;
    logic        drain_m = 1'b0;
    logic [15:0] hit_pc = 16'h0005;
    logic [15:0] hit_npc = 16'h0040;
    logic [48:0] exp_q[$];

    fetch_unit #(.WORD_SIZE(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pred_npc     (pred_npc),
        .pred_taken   (pred_taken),
        .pc_out       (pc_out),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_stall     (id_stall),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pred_npc  (if_pred_npc),
        .if_pred_taken(if_pred_taken),
        .debug_state  (debug_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Predictor: sequential pc+1 except for one taken entry
    assign pred_taken = (pc_out == hit_pc);
    assign pred_npc   = pred_taken ? hit_npc : pc_out + 16'd1;

    // Memory: completes after wait_n wait cycles, data is a fixed function of the address
    assign mem_ready = mem_req && (wait_cnt >= wait_n);
    assign mem_data  = mem_addr ^ 16'hBEEF;

    always @(posedge clk) begin
        if (!mem_req || mem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Scoreboard: every completed correct-path read is an entry; decode consumes them in order.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            drain_m <= 1'b0;
        end else begin
            if (if_valid && !id_stall) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    check_eq("sb_entry", {if_instr, if_pc, if_pred_npc, if_pred_taken}, exp_q.pop_front());
                    n_pops++;
                end
            end
            if (redirect) exp_q.delete();
            else if (mem_req && mem_ready && !drain_m)
                exp_q.push_back({mem_data, mem_addr, pred_npc, pred_taken});
            drain_m <= mem_req && !mem_ready && (redirect || drain_m);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset(input int waits);
        reset_n     = 1'b0;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        wait_n      = waits;
        repeat (2) tick();
        sample();
        check_eq("rst_req_low", mem_req, 1'b0);
        check_eq("rst_valid_low", if_valid, 1'b0);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // Zero-wait streaming and predictor hit at 0x0005
        do_reset(0);
        sample();
        check_eq("s1_valid0", if_valid, 1'b0);
        check_eq("s1_pc0", pc_out, 16'h0000);
        check_eq("s1_req", mem_req, 1'b1);
        check_eq("s1_state", debug_state, S_FETCH);
        for (int k = 2; k <= 7; k++) begin
            tick();
            sample();
            check_eq("s1_if_valid", if_valid, 1'b1);
            check_eq("s1_if_pc", if_pc, 16'(k - 2));
        end
        check_eq("s1_hit_npc", if_pred_npc, 16'h0040);
        check_eq("s1_hit_taken", if_pred_taken, 1'b1);
        check_eq("s1_hit_instr", if_instr, 16'h0005 ^ 16'hBEEF);
        check_eq("s1_hit_addr", mem_addr, 16'h0040);

        // Two wait states: address held 3 cycles, one entry per 3 cycles
        do_reset(2);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) tick();
            sample();
            check_eq("s2_addr", mem_addr, 16'((k - 1) / 3));
            check_eq("s2_valid", if_valid, (k % 3 == 1) && (k > 1));
            if ((k % 3 == 1) && (k > 1)) check_eq("s2_if_pc", if_pc, 16'((k - 4) / 3));
        end

        // Decode stall while a fetch completes -> HOLD, then skid entry released
        do_reset(0);
        repeat (3) tick();
        id_stall = 1'b1;
        sample();
        check_eq("s3_pc_a", if_pc, 16'd2);
        check_eq("s3_state_a", debug_state, S_FETCH);
        for (int j = 0; j < 2; j++) begin
            tick();
            sample();
            check_eq("s3_hold_state", debug_state, S_HOLD);
            check_eq("s3_hold_req", mem_req, 1'b0);
            check_eq("s3_hold_valid", if_valid, 1'b1);
            check_eq("s3_hold_pc", if_pc, 16'd2);
        end
        tick();
        id_stall = 1'b0;
        sample();
        check_eq("s3_rel_state", debug_state, S_HOLD);
        check_eq("s3_rel_pc", if_pc, 16'd2);
        tick();
        sample();
        check_eq("s3_skid_pc", if_pc, 16'd3);
        check_eq("s3_skid_state", debug_state, S_FETCH);
        check_eq("s3_skid_req", mem_req, 1'b1);
        tick();
        sample();
        check_eq("s3_next_pc", if_pc, 16'd4);

        // Redirect with mem_ready, redirect into DRAIN, latest redirect wins, reset mid-DRAIN
        do_reset(2);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        sample();
        check_eq("s4_coinc_addr", mem_addr, 16'h0000);
        tick();
        redirect_pc = 16'h0100;
        sample();
        check_eq("s4_new_addr", mem_addr, 16'h0010);
        check_eq("s4_discard_valid", if_valid, 1'b0);
        check_eq("s4_state_f", debug_state, S_FETCH);
        tick();
        redirect = 1'b0;
        sample();
        check_eq("s4_drain_addr", mem_addr, 16'h0010);
        check_eq("s4_drain_state", debug_state, S_DRAIN);
        check_eq("s4_drain_valid", if_valid, 1'b0);
        tick();
        sample();
        check_eq("s4_drain_addr2", mem_addr, 16'h0010);
        check_eq("s4_drain_req", mem_req, 1'b1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        sample();
        check_eq("s4_target_addr", mem_addr, 16'h0100);
        check_eq("s4_target_valid", if_valid, 1'b0);
        tick();
        redirect_pc = 16'h0200;
        sample();
        check_eq("s5_drain_state", debug_state, S_DRAIN);
        check_eq("s5_drain_addr", mem_addr, 16'h0100);
        tick();
        redirect = 1'b0;
        sample();
        check_eq("s5_drain_addr2", mem_addr, 16'h0100);
        tick();
        sample();
        check_eq("s5_latest_addr", mem_addr, 16'h0200);
        check_eq("s5_latest_state", debug_state, S_FETCH);
        tick();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0500;
        sample();
        check_eq("s5_first_valid", if_valid, 1'b1);
        check_eq("s5_first_pc", if_pc, 16'h0200);
        check_eq("s5_next_addr", mem_addr, 16'h0201);
        tick();
        redirect = 1'b0;
        sample();
        check_eq("s6_drain_state", debug_state, S_DRAIN);
        check_eq("s6_drain_valid", if_valid, 1'b0);
        tick();
        reset_n = 1'b0;
        sample();
        check_eq("s6_rst_req", mem_req, 1'b0);
        tick();
        reset_n = 1'b1;
        sample();
        check_eq("s6_pc", pc_out, 16'h0000);
        check_eq("s6_valid", if_valid, 1'b0);
        check_eq("s6_state", debug_state, S_FETCH);
        check_eq("s6_req", mem_req, 1'b1);
        repeat (3) tick();
        sample();
        check_eq("s6_first_valid", if_valid, 1'b1);
        check_eq("s6_first_pc", if_pc, 16'h0000);

        // Random stalls, wait states and redirects, checked by the scoreboard
        do_reset(1);
        n_pops = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            wait_n      = $urandom_range(0, 2);
            id_stall    = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom_range(0, 65535));
        end
        tick();
        id_stall = 1'b0;
        redirect = 1'b0;
        repeat (10) tick();
        check_eq("rand_progress", n_pops > 50, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
